window_3x3_gen: RTL

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

---
 rtl/window_3x3_gen.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/window_3x3_gen.sv
// window_3x3_gen
// ---------------------------------------------------------------------------
// Turns a raster-order pixel stream into 3x3 neighbourhood windows. It uses
// two line buffers (one-line and two-line delays) and a two-column history of
// the window. A window is emitted one clock after the pixel that completes it.
// Windows are only emitted when that pixel sits at column >= 2 and row >= 2,
// so there is no border padding and no window spans a line boundary.
//
// Handshake: in_valid qualifies in_pixel and in_sof for one cycle. There is
// no backpressure, so every cycle with in_valid=1 consumes a pixel. out_valid
// is a one-cycle strobe; p0..p8 and frame_done are meaningful only while it
// is high, and p0..p8 hold their last window otherwise.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid         pixel accepted this cycle
//   in_sof           accepted pixel is (0,0) of a new frame
//   in_pixel         raster-order pixel, PIX_W bits
//   p0..p8           window; p0-p2 top row, p6-p8 bottom row, left to right
//   out_valid        p0..p8 carry a new window this cycle
//   frame_done       asserted with the window whose pixel was (IMG_W-1,IMG_H-1)
// ---------------------------------------------------------------------------
module window_3x3_gen #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int PIX_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic [PIX_W-1:0] p0,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
  output logic [PIX_W-1:0] p4,
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic [PIX_W-1:0] p8,
  output logic             out_valid,
  output logic             frame_done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  // Position of the pixel being accepted. A start-of-frame pixel is forced
  // to (0,0) so any partial frame is dropped; because windows need rows
  // y-1 and y-2 of the current frame, stale line-buffer content from an
  // abandoned frame (or from before reset) is overwritten before use.
  logic [XW-1:0] ex;
  logic [YW-1:0] ey;
  assign ex = in_sof ? '0 : x_q;
  assign ey = in_sof ? '0 : y_q;

  logic x_last, y_last, emit, last_pix;
  assign x_last   = (32'(ex) == IMG_W - 1);
  assign y_last   = (32'(ey) == IMG_H - 1);
  assign emit     = in_valid && (32'(ex) >= 2) && (32'(ey) >= 2);
  assign last_pix = in_valid && x_last && y_last;

  // Line buffers: lb1[x] = pixel(x,y-1), lb2[x] = pixel(x,y-2).
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb2 [IMG_W];
  logic [PIX_W-1:0] top_new, mid_new;
  assign top_new = lb2[ex];
  assign mid_new = lb1[ex];

  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb2[ex] <= lb1[ex];
      lb1[ex] <= in_pixel;
    end
  end

  // Column history: c0 = column x-2, c1 = column x-1 (top/mid/bot rows).
  // The newest column is taken straight from the line buffers and input.
  logic [PIX_W-1:0] c0_t, c0_m, c0_b;
  logic [PIX_W-1:0] c1_t, c1_m, c1_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      c0_t <= '0;
      c0_m <= '0;
      c0_b <= '0;
      c1_t <= '0;
      c1_m <= '0;
      c1_b <= '0;
    end else if (in_valid) begin
      c0_t <= c1_t;
      c0_m <= c1_m;
      c0_b <= c1_b;
      c1_t <= top_new;
      c1_m <= mid_new;
      c1_b <= in_pixel;
      if (x_last) begin
        x_q <= '0;
        y_q <= y_last ? '0 : ey + 1'b1;
      end else begin
        x_q <= ex + 1'b1;
        y_q <= ey;
      end
    end
  end

  // Output registers load only when a window is emitted, so p0..p8 stay
  // stable between windows even though the column history keeps shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0         <= '0;
      p1         <= '0;
      p2         <= '0;
      p3         <= '0;
      p4         <= '0;
      p5         <= '0;
      p6         <= '0;
      p7         <= '0;
      p8         <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= emit;
      frame_done <= last_pix;
      if (emit) begin
        p0 <= c0_t;
        p1 <= c1_t;
        p2 <= top_new;
        p3 <= c0_m;
        p4 <= c1_m;
        p5 <= mid_new;
        p6 <= c0_b;
        p7 <= c1_b;
        p8 <= in_pixel;
      end
    end
  end

endmodule
